// File: rtl/lfsr_descrambler_par.sv
// Parallel LFSR descrambler: DATA_W bits per beat, additive or self-synchronising mode,
// runtime seed load, registered data output with valid.
module lfsr_descrambler_par #(
   parameter int unsigned             LFSR_W = 15,
   parameter int unsigned             TAP_A  = 14,
   parameter int unsigned             TAP_B  = 13,
   parameter int unsigned             DATA_W = 8,
   parameter logic [LFSR_W-1:0]       SEED   = 15'h57E5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mode,
   input  logic                enable,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                seed_load,
   input  logic [LFSR_W-1:0]   seed_in,
   output logic [DATA_W-1:0]   data_out,
   output logic                out_valid,
   output logic [LFSR_W-1:0]   lfsr_state
);

   logic [LFSR_W-1:0] s;
   logic [LFSR_W-1:0] step_state;
   logic [DATA_W-1:0] step_out;
   logic              fb;

   // Unrolled DATA_W bit-steps; a same-cycle seed load replaces the old state as the start point
   always_comb begin
      step_state = seed_load ? seed_in : s;
      step_out   = '0;
      fb         = 1'b0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         fb = step_state[TAP_A] ^ step_state[TAP_B];
         if (mode) begin
            step_out[i] = data_in[i] ^ (fb & enable);
            step_state  = {step_state[LFSR_W-2:0], data_in[i]};
         end else begin
            step_out[i] = data_in[i] ^ (step_state[0] & enable);
            step_state  = {step_state[LFSR_W-2:0], fb};
         end
      end
   end

   // State and output registers; reset overrides valid and seed load
   always_ff @(posedge clk) begin
      if (!rst) begin
         s         <= SEED;
         data_out  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            s        <= step_state;
            data_out <= step_out;
         end else if (seed_load) begin
            s <= seed_in;
         end
      end
   end

   assign lfsr_state = s;

endmodule

// File: tb/tb_lfsr_descrambler_par.sv
// Directed bench for lfsr_descrambler_par: hand-computed vector table plus
// round-trip and self-sync sequences against reference scramblers.
module tb_lfsr_descrambler_par;

   logic        clk;
   logic        rst;
   logic        mode;
   logic        enable;
   logic        in_valid;
   logic [7:0]  data_in;
   logic        seed_load;
   logic [14:0] seed_in;
   logic [7:0]  data_out;
   logic        out_valid;
   logic [14:0] lfsr_state;

   int n_vec;
   int n_bad;

   lfsr_descrambler_par dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .enable     (enable),
      .in_valid   (in_valid),
      .data_in    (data_in),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .lfsr_state (lfsr_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        mode;
      logic        enable;
      logic        in_valid;
      logic        seed_load;
      logic [7:0]  data;
      logic [14:0] seed;
      logic        ev;
      logic [7:0]  ed;
      logic [14:0] es;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(input logic r, input logic m, input logic e, input logic v,
                               input logic sl, input logic [7:0] d, input logic [14:0] sd,
                               input logic ev, input logic [7:0] ed, input logic [14:0] es);
      vec_t t;
      t.rst = r; t.mode = m; t.enable = e; t.in_valid = v; t.seed_load = sl;
      t.data = d; t.seed = sd; t.ev = ev; t.ed = ed; t.es = es;
      return t;
   endfunction

   task automatic set_in(input logic r, input logic m, input logic e, input logic v,
                         input logic sl, input logic [7:0] d, input logic [14:0] sd);
      rst = r; mode = m; enable = e; in_valid = v; seed_load = sl; data_in = d; seed_in = sd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference additive scrambler: keystream bit is s[0], feedback s[14]^s[13]
   task automatic add_scr(input logic [7:0] p, input logic [14:0] si,
                          output logic [7:0] c, output logic [14:0] so);
      logic [14:0] r;
      logic        f;
      r = si;
      c = '0;
      for (int i = 0; i < 8; i++) begin
         c[i] = p[i] ^ r[0];
         f    = r[14] ^ r[13];
         r    = {r[13:0], f};
      end
      so = r;
   endtask

   // Reference multiplicative scrambler: scrambled bit is shifted into the register
   task automatic mul_scr(input logic [7:0] p, input logic [14:0] si,
                          output logic [7:0] c, output logic [14:0] so);
      logic [14:0] r;
      r = si;
      c = '0;
      for (int i = 0; i < 8; i++) begin
         c[i] = p[i] ^ r[14] ^ r[13];
         r    = {r[13:0], c[i]};
      end
      so = r;
   endtask

   logic [7:0]  plain[64];
   logic [7:0]  scr[64];
   logic [14:0] ref_s;
   logic [14:0] held;

   // Round trip of 64 additive-scrambled bytes with random idle gaps
   task automatic round_trip(input logic use_seed, input logic [14:0] start);
      logic [7:0] c;
      ref_s = start;
      for (int b = 0; b < 64; b++) begin
         plain[b] = 8'($urandom_range(0, 255));
         add_scr(plain[b], ref_s, c, ref_s);
         scr[b] = c;
      end
      for (int b = 0; b < 64; b++) begin
         if ($urandom_range(0, 2) == 0) begin
            held = lfsr_state;
            set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 15'h0000);
            step();
            check("gap_out_valid", 32'(out_valid), 32'd0);
            check("gap_state_hold", 32'(lfsr_state), 32'(held));
         end
         set_in(1'b1, 1'b0, 1'b1, 1'b1, (use_seed && b == 0), scr[b], start);
         step();
         check("rt_out_valid", 32'(out_valid), 32'd1);
         check("rt_data", 32'(data_out), 32'(plain[b]));
      end
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 15'h0000);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 15'h0000);

      //           rst  mode en   vld  sl   data   seed      ev   ed     es
      vecs[0]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 15'h0000, 1'b0, 8'h00, 15'h57E5);
      vecs[1]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 15'h0000, 1'b1, 8'h1F, 15'h65F0);
      vecs[2]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 15'h0000, 1'b0, 8'h1F, 15'h65F0);
      vecs[3]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 15'h0000, 1'b1, 8'h74, 15'h705C);
      vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 15'h1111, 1'b0, 8'h00, 15'h57E5);
      vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 15'h0000, 1'b1, 8'h00, 15'h65F0);
      vecs[6]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 15'h1234, 1'b0, 8'h00, 15'h1234);
      vecs[7]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 15'h0001, 1'b1, 8'h01, 15'h0100);
      vecs[8]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 15'h0000, 1'b0, 8'h01, 15'h0000);
      vecs[9]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 15'h0000, 1'b1, 8'hA5, 15'h0000);
      vecs[10] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 15'h0000, 1'b1, 8'hFF, 15'h00FF);
      vecs[11] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 15'h0000, 1'b1, 8'h40, 15'h7F00);
      vecs[12] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 15'h0000, 1'b1, 8'h80, 15'h0002);

      for (int i = 0; i < 13; i++) begin
         set_in(vecs[i].rst, vecs[i].mode, vecs[i].enable, vecs[i].in_valid,
                vecs[i].seed_load, vecs[i].data, vecs[i].seed);
         step();
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
         check($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].ed));
         check($sformatf("vec%0d_state", i), 32'(lfsr_state), 32'(vecs[i].es));
      end

      // Round trip from reset seed, then with seed load on the first beat
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 15'h0000);
      step();
      round_trip(1'b0, 15'h57E5);
      round_trip(1'b1, 15'h1234);

      // Self-sync recovery from a mismatched starting state
      begin
         logic [7:0] c;
         set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 15'h7FFF);
         step();
         ref_s = 15'h0001;
         for (int b = 0; b < 16; b++) begin
            plain[b] = 8'($urandom_range(0, 255));
            mul_scr(plain[b], ref_s, c, ref_s);
            set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, c, 15'h0000);
            step();
            if (b >= 2) check($sformatf("ss_beat%0d", b), 32'(data_out), 32'(plain[b]));
         end
      end

      // Mid-stream reset with a valid beat present, then first beat after release
      set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 15'h0000);
      step();
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 15'h0000);
      step();
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data", 32'(data_out), 32'd0);
      check("mid_rst_state", 32'(lfsr_state), 32'h57E5);
      set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 15'h0000);
      step();
      check("post_rst_valid", 32'(out_valid), 32'd1);
      check("post_rst_data", 32'(data_out), 32'h1F);
      check("post_rst_state", 32'(lfsr_state), 32'h65F0);
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 15'h0000);
      step();
      check("post_rst_valid_drop", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
